ysyx_25020047_lsu: RTL

- Load/store stage directly downstream of the execute unit.
- Consumes the execute result (ALU value or effective address), the store operand, the read/write/reg_wen flags and the one-hot inst_type.
- Performs at most one data-memory transaction per instruction over a req/ack handshake, then presents a single write-back beat to the register file stage.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/ysyx_25020047_lsu_if.sv | 54 +++++
 rtl/ysyx_25020047_lsu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu_if.sv
// Bundle of the LSU's three channels: execute input, data-memory
// request/ack, and register-file write-back. The LSU takes the master
// view; the execute stage, memory and write-back consumer together take
// the slave view.
interface ysyx_25020047_lsu_if #(
  parameter int ADDR_W = 32
);
  // execute -> LSU
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst_type;
  logic [ADDR_W-1:0] in_result;
  logic [ADDR_W-1:0] in_rdata2;
  logic              in_reg_wen;
  logic              in_read;
  logic              in_write;
  logic [4:0]        in_rd;

  // LSU <-> data memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_rdata;

  // LSU -> write-back
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_data;
  logic [4:0]        wb_rd;
  logic              wb_wen;

  modport master (
    input  in_valid, in_inst_type, in_result, in_rdata2,
    input  in_reg_wen, in_read, in_write, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata,
    output wb_valid, wb_data, wb_rd, wb_wen,
    input  wb_ready
  );

  modport slave (
    output in_valid, in_inst_type, in_result, in_rdata2,
    output in_reg_wen, in_read, in_write, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata,
    input  wb_valid, wb_data, wb_rd, wb_wen,
    output wb_ready
  );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Load/store stage: accepts one instruction from execute, issues at most
// one data-memory access over req/ack, then holds a single write-back beat
// until the register-file stage takes it. Errors (illegal access, memory
// timeout) are reported through a sticky flag and a write-back with wen=0.
module ysyx_25020047_lsu #(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25020047_lsu_if.master         bus,
  output logic                        lsu_err
);

  localparam logic [31:0] OP_LW  = 32'h0000_0020;
  localparam logic [31:0] OP_LBU = 32'h0000_0040;
  localparam logic [31:0] OP_SW  = 32'h0000_0080;
  localparam logic [31:0] OP_SB  = 32'h0000_0100;
  localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_wen_q, wb_wen_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              op_lbu_q, op_lbu_d;
  logic              reg_wen_q, reg_wen_d;
  logic [1:0]        byte_sel_q, byte_sel_d;

  // Decode of the incoming instruction (only meaningful in IDLE)
  logic       is_lw, is_lbu, is_sw, is_sb, is_mem, is_store, illegal;
  logic [7:0] cnt_inc;
  logic [7:0] load_byte;

  assign is_lw    = (bus.in_inst_type == OP_LW);
  assign is_lbu   = (bus.in_inst_type == OP_LBU);
  assign is_sw    = (bus.in_inst_type == OP_SW);
  assign is_sb    = (bus.in_inst_type == OP_SB);
  assign is_mem   = is_lw | is_lbu | is_sw | is_sb;
  assign is_store = is_sw | is_sb;
  // Conflicting flags or a misaligned word access never reaches memory.
  assign illegal  = (bus.in_read & bus.in_write) |
                    ((is_lw | is_sw) & (bus.in_result[1:0] != 2'b00));
  assign cnt_inc  = cnt_q + 8'd1;

  // Pick the addressed byte of the returned word for lbu.
  always_comb begin
    load_byte = bus.mem_rdata[7:0];
    case (byte_sel_q)
      2'd0:    load_byte = bus.mem_rdata[7:0];
      2'd1:    load_byte = bus.mem_rdata[15:8];
      2'd2:    load_byte = bus.mem_rdata[23:16];
      default: load_byte = bus.mem_rdata[31:24];
    endcase
  end

  // Next-state and next-output logic of the IDLE/WAIT/WB controller.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_wen_d    = wb_wen_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    op_lbu_d    = op_lbu_q;
    reg_wen_d   = reg_wen_q;
    byte_sel_d  = byte_sel_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_lbu_d   = is_lbu;
          reg_wen_d  = bus.in_reg_wen;
          byte_sel_d = bus.in_result[1:0];
          wb_rd_d    = bus.in_rd;
          cnt_d      = 8'd0;
          if (illegal) begin
            err_d     = 1'b1;
            wb_wen_d  = 1'b0;
            wb_data_d = '0;
            state_d   = S_WB;
          end else if (is_mem) begin
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = {bus.in_result[ADDR_W-1:2], 2'b00};
            if (is_sw) begin
              mem_wdata_d = bus.in_rdata2;
              mem_wmask_d = 4'hF;
            end else if (is_sb) begin
              mem_wdata_d = {(ADDR_W/8){bus.in_rdata2[7:0]}};
              mem_wmask_d = 4'b0001 << bus.in_result[1:0];
            end else begin
              mem_wdata_d = '0;
              mem_wmask_d = 4'h0;
            end
            state_d = S_WAIT;
          end else begin
            wb_data_d = bus.in_result;
            wb_wen_d  = bus.in_reg_wen;
            state_d   = S_WB;
          end
        end
      end

      S_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_WB;
          if (mem_we_q) begin
            wb_wen_d  = 1'b0;
            wb_data_d = '0;
          end else begin
            wb_wen_d  = reg_wen_q;
            wb_data_d = op_lbu_q ? {{(ADDR_W-8){1'b0}}, load_byte} : bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
          // Memory never answered: abandon the access and flag it.
          if (cnt_inc == TIMEOUT_LIM) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            wb_wen_d  = 1'b0;
            wb_data_d = '0;
            state_d   = S_WB;
          end
        end
      end

      S_WB: begin
        if (bus.wb_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'h0;
      wb_data_q   <= '0;
      wb_rd_q     <= 5'd0;
      wb_wen_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      op_lbu_q    <= 1'b0;
      reg_wen_q   <= 1'b0;
      byte_sel_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_wen_q    <= wb_wen_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      op_lbu_q    <= op_lbu_d;
      reg_wen_q   <= reg_wen_d;
      byte_sel_q  <= byte_sel_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.wb_valid  = (state_q == S_WB);
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_wen    = wb_wen_q;
  assign lsu_err       = err_q;

endmodule
